// File: rtl/matmul_pkg.sv
// Shared constants and state type for the matmul sequencer slice.
package matmul_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned N         = 4;
  localparam int unsigned FEED_LAST = 7;
  localparam int unsigned WDOG_MAX  = 63;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/matmul_skew.sv
// Combinational diagonal skew: lane i carries element k = i + N - c of its
// matrix row/column, or zero when k falls outside the matrix.
module matmul_skew
  import matmul_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [5:0]      c_i,
  input  logic [DW-1:0]   a_i [N][N],
  input  logic [DW-1:0]   b_i [N][N],
  output logic [N*DW-1:0] lane_a_o,
  output logic [N*DW-1:0] lane_b_o
);

  int k;

  always_comb begin
    lane_a_o = '0;
    lane_b_o = '0;
    k        = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = int'(i) + int'(N) - int'(c_i);
      if (k >= 0 && k < int'(N)) begin
        lane_a_o[(N-i)*DW-1 -: DW] = a_i[i[1:0]][k[1:0]];
        lane_b_o[(N-i)*DW-1 -: DW] = b_i[k[1:0]][i[1:0]];
      end
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer for the 4x4 systolic matmul: operand storage, skewed feed,
// result capture and a valid/ready result stream.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_sel,
  input  logic [1:0]      ld_row,
  input  logic [4*DW-1:0] ld_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            mm_rst,
  output logic            mm_start,
  output logic [3:0]      mm_counter,
  output logic [4*DW-1:0] mm_inA_flat,
  output logic [4*DW-1:0] mm_inB_flat,
  input  logic            mm_output_rdy,
  input  logic [4*DW-1:0] mm_outD_flat,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [1:0]      res_row,
  output logic [4*DW-1:0] res_data
);

  seq_state_t state_q, state_d;
  logic [5:0] c_q, c_d;
  logic [2:0] ri_q;
  logic [1:0] oi_q;
  logic       done_q, err_q;

  logic [DW-1:0]   a_q [N][N];
  logic [DW-1:0]   b_q [N][N];
  logic [N*DW-1:0] rbuf_q [N];

  logic            mm_start_q;
  logic [3:0]      mm_counter_q;
  logic [N*DW-1:0] lane_a_q, lane_b_q;
  logic [N*DW-1:0] lane_a, lane_b;

  logic ld_acc, start_acc, exit_ok, wdog, cap, res_acc, run_d;

  assign ld_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign mm_rst      = ~rst_n;
  assign mm_start    = mm_start_q;
  assign mm_counter  = mm_counter_q;
  assign mm_inA_flat = lane_a_q;
  assign mm_inB_flat = lane_b_q;
  // The done cycle sits between RUN and the first result beat.
  assign res_valid   = (state_q == RESULT) && !done_q;
  assign res_row     = oi_q;
  assign res_data    = rbuf_q[oi_q];

  always_comb begin
    ld_acc    = ld_valid && ld_ready;
    start_acc = (state_q == IDLE) && start;
    exit_ok   = (state_q == RUN) && (ri_q == 3'd4) && (c_q >= 6'(FEED_LAST));
    wdog      = (state_q == RUN) && !exit_ok && (c_q == 6'(WDOG_MAX));
    cap       = (state_q == RUN) && mm_output_rdy && (ri_q < 3'd4);
    res_acc   = res_valid && res_ready;
    state_d   = state_q;
    c_d       = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          c_d     = '0;
        end
      end
      RUN: begin
        if (exit_ok || wdog) begin
          state_d = RESULT;
          c_d     = '0;
        end else begin
          c_d = c_q + 6'd1;
        end
      end
      RESULT: begin
        if (res_acc && oi_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUN);
  end

  // Feed outputs are computed from next-state values so that the registered
  // counter and lanes always show the same c.
  matmul_skew #(.DW(DW)) u_skew (
    .c_i      (c_d),
    .a_i      (a_q),
    .b_i      (b_q),
    .lane_a_o (lane_a),
    .lane_b_o (lane_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      c_q          <= '0;
      ri_q         <= '0;
      oi_q         <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mm_start_q   <= 1'b0;
      mm_counter_q <= '0;
      lane_a_q     <= '0;
      lane_b_q     <= '0;
      for (int unsigned r = 0; r < N; r++) begin
        rbuf_q[r] <= '0;
        for (int unsigned j = 0; j < N; j++) begin
          a_q[r][j] <= '0;
          b_q[r][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      done_q  <= exit_ok || wdog;

      if (start_acc)  err_q <= 1'b0;
      else if (wdog)  err_q <= 1'b1;

      if (ld_acc) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (ld_sel) b_q[ld_row][j[1:0]] <= ld_data[(N-j)*DW-1 -: DW];
          else        a_q[ld_row][j[1:0]] <= ld_data[(N-j)*DW-1 -: DW];
        end
      end

      if (start_acc) begin
        ri_q <= '0;
        for (int unsigned r = 0; r < N; r++) rbuf_q[r] <= '0;
      end else if (cap) begin
        rbuf_q[ri_q[1:0]] <= mm_outD_flat;
        ri_q              <= ri_q + 3'd1;
      end

      if (start_acc)    oi_q <= '0;
      else if (res_acc) oi_q <= oi_q + 2'd1;

      mm_start_q   <= run_d && (c_d == '0);
      mm_counter_q <= !run_d ? 4'd0 : (c_d > 6'd15) ? 4'hF : c_d[3:0];
      lane_a_q     <= run_d ? lane_a : '0;
      lane_b_q     <= run_d ? lane_b : '0;
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq with a behavioural matmul stand-in that
// rebuilds A and B from the skewed lanes and returns their product.
module tb_matmul_seq;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ld_valid, ld_ready, ld_sel;
  logic [1:0]      ld_row;
  logic [4*DW-1:0] ld_data;
  logic            start, busy, done, err, mm_rst, mm_start;
  logic [3:0]      mm_counter;
  logic [4*DW-1:0] mm_inA_flat, mm_inB_flat;
  logic            mm_output_rdy;
  logic [4*DW-1:0] mm_outD_flat;
  logic            res_valid, res_ready;
  logic [1:0]      res_row;
  logic [4*DW-1:0] res_data;

  always #5 clk = ~clk;

  matmul_seq #(.DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_sel        (ld_sel),
    .ld_row        (ld_row),
    .ld_data       (ld_data),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .mm_rst        (mm_rst),
    .mm_start      (mm_start),
    .mm_counter    (mm_counter),
    .mm_inA_flat   (mm_inA_flat),
    .mm_inB_flat   (mm_inB_flat),
    .mm_output_rdy (mm_output_rdy),
    .mm_outD_flat  (mm_outD_flat),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_row       (res_row),
    .res_data      (res_data)
  );

  typedef struct {
    logic [1:0]      row;
    logic [4*DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [4*DW-1:0] pk(input int unsigned e0, input int unsigned e1,
                                         input int unsigned e2, input int unsigned e3);
    return {e0, e1, e2, e3};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, ex);
    end
  endtask

  task automatic push(input logic [1:0] r, input logic [4*DW-1:0] d);
    exp_t e;
    e.row  = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Behavioural matmul: record lanes during feed, answer with npulse rows.
  int          npulse = 4;
  int          p = 0;
  int          start_cnt = 0;
  logic [DW-1:0] ra [4][4];
  logic [DW-1:0] rb [4][4];

  initial begin
    mm_output_rdy = 1'b0;
    mm_outD_flat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mm_output_rdy = 1'b0;
        p = 0;
      end else begin
        if (mm_start) begin
          start_cnt++;
          p = 0;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
              ra[i][j] = 'x;
              rb[i][j] = 'x;
            end
        end
        if (busy && mm_counter >= 4'd1 && mm_counter <= 4'd7) begin
          for (int i = 0; i < 4; i++) begin
            int k;
            k = i + 4 - int'(mm_counter);
            if (k >= 0 && k <= 3) begin
              ra[i][k] = mm_inA_flat[(4-i)*DW-1 -: DW];
              rb[k][i] = mm_inB_flat[(4-i)*DW-1 -: DW];
            end
          end
        end
        if (busy && mm_counter >= 4'd8 && p < npulse) begin
          mm_output_rdy = 1'b1;
          if (p < 4) begin
            for (int j = 0; j < 4; j++) begin
              logic [DW-1:0] s;
              s = '0;
              for (int k = 0; k < 4; k++) s = s + ra[p][k] * rb[k][j];
              mm_outD_flat[(4-j)*DW-1 -: DW] = s;
            end
          end else begin
            mm_outD_flat = {4{32'hDEAD_BEEF}};
          end
          p++;
        end else begin
          mm_output_rdy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops on every accepted result beat and checks stall stability.
  initial begin
    logic            stall;
    logic [1:0]      prow;
    logic [4*DW-1:0] pdata;
    exp_t            e;
    stall = 1'b0;
    prow  = '0;
    pdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && stall && res_valid) begin
        chk("hold_row", 128'(res_row), 128'(prow));
        chk("hold_data", res_data, pdata);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got row %0d data %0h, required no beat", res_row, res_data);
        end else begin
          e = exp_q.pop_front();
          chk("res_row", 128'(res_row), 128'(e.row));
          chk("res_data", res_data, e.data);
        end
      end
      stall = res_valid && !res_ready;
      prow  = res_row;
      pdata = res_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [1:0] row, input logic [4*DW-1:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = row;
    ld_data  = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, 128'(seen), 128'(1));
  endtask

  task automatic wait_counter(input string nm, input logic [3:0] v);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && mm_counter == v) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, 128'(seen), 128'(1));
  endtask

  task automatic drain(input logic [3:0] pat);
    logic idle;
    idle = 1'b0;
    step();
    for (int i = 0; i < 40; i++) begin
      res_ready = pat[i[1:0]];
      step();
      if (ld_ready) begin
        idle = 1'b1;
        break;
      end
    end
    res_ready = 1'b0;
    chk("back_to_idle", 128'(idle), 128'(1));
    chk("idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    ld_valid  = 1'b0;
    ld_sel    = 1'b0;
    ld_row    = '0;
    ld_data   = '0;
    start     = 1'b0;
    res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mm_rst", 128'(mm_rst), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_ld_ready", 128'(ld_ready), 128'(1));
    chk("rst_flags", 128'({busy, done, err, mm_start, res_valid, mm_rst}), 128'(0));
    chk("rst_counter", 128'(mm_counter), 128'(0));
    chk("rst_lane_a", mm_inA_flat, '0);
    chk("rst_lane_b", mm_inB_flat, '0);

    // Identity: B = I, five output pulses (fifth ignored).
    load(1'b0, 2'd0, pk(1, 2, 3, 4));
    load(1'b0, 2'd1, pk(5, 6, 7, 8));
    load(1'b0, 2'd2, pk(9, 10, 11, 12));
    load(1'b0, 2'd3, pk(13, 14, 15, 16));
    load(1'b1, 2'd0, pk(1, 0, 0, 0));
    load(1'b1, 2'd1, pk(0, 1, 0, 0));
    load(1'b1, 2'd2, pk(0, 0, 1, 0));
    load(1'b1, 2'd3, pk(0, 0, 0, 1));
    push(2'd0, pk(1, 2, 3, 4));
    push(2'd1, pk(5, 6, 7, 8));
    push(2'd2, pk(9, 10, 11, 12));
    push(2'd3, pk(13, 14, 15, 16));
    npulse    = 5;
    start_cnt = 0;
    do_start();
    wait_counter("id_counter4", 4'd4);
    chk("id_lane_a_c4", mm_inA_flat, pk(1, 6, 11, 16));
    chk("id_lane_b_c4", mm_inB_flat, pk(1, 1, 1, 1));
    wait_done("id_done");
    chk("id_err", 128'(err), 128'(0));
    drain(4'b1111);
    chk("id_start_count", 128'(start_cnt), 128'(1));

    // General: out-of-order loads, B row 2 rewritten in the start cycle.
    load(1'b0, 2'd2, pk(9, 10, 11, 12));
    load(1'b0, 2'd0, pk(1, 2, 3, 4));
    load(1'b0, 2'd3, pk(13, 14, 15, 16));
    load(1'b0, 2'd1, pk(5, 6, 7, 8));
    load(1'b1, 2'd3, pk(2, 2, 2, 2));
    load(1'b1, 2'd0, pk(2, 2, 2, 2));
    load(1'b1, 2'd2, pk(9, 9, 9, 9));
    load(1'b1, 2'd1, pk(2, 2, 2, 2));
    push(2'd0, pk(20, 20, 20, 20));
    push(2'd1, pk(52, 52, 52, 52));
    push(2'd2, pk(84, 84, 84, 84));
    push(2'd3, pk(116, 116, 116, 116));
    npulse    = 4;
    start_cnt = 0;
    ld_valid  = 1'b1;
    ld_sel    = 1'b1;
    ld_row    = 2'd2;
    ld_data   = pk(2, 2, 2, 2);
    start     = 1'b1;
    step();
    ld_valid  = 1'b0;
    start     = 1'b0;
    repeat (3) step();
    ld_valid  = 1'b1;
    ld_sel    = 1'b0;
    ld_row    = 2'd1;
    ld_data   = pk(7, 7, 7, 7);
    start     = 1'b1;
    chk("run_ld_ready", 128'(ld_ready), 128'(0));
    step();
    step();
    ld_valid  = 1'b0;
    start     = 1'b0;
    wait_done("gen_done");
    drain(4'b1001);
    chk("gen_start_count", 128'(start_cnt), 128'(1));

    // Watchdog: only two rows come back; matrices unchanged from above.
    push(2'd0, pk(20, 20, 20, 20));
    push(2'd1, pk(52, 52, 52, 52));
    push(2'd2, '0);
    push(2'd3, '0);
    npulse = 2;
    do_start();
    wait_done("wd_done");
    chk("wd_err", 128'(err), 128'(1));
    drain(4'b1111);
    chk("wd_err_sticky", 128'(err), 128'(1));
    npulse = 4;
    push(2'd0, pk(20, 20, 20, 20));
    push(2'd1, pk(52, 52, 52, 52));
    push(2'd2, pk(84, 84, 84, 84));
    push(2'd3, pk(116, 116, 116, 116));
    do_start();
    chk("err_cleared", 128'(err), 128'(0));
    wait_done("clr_done");
    chk("clr_err", 128'(err), 128'(0));
    drain(4'b1111);

    // Reset mid-RUN at c = 5.
    do_start();
    wait_counter("rr_counter5", 4'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_flags", 128'({busy, done, err, mm_start, res_valid}), 128'(0));
    chk("rr_mm_rst", 128'(mm_rst), 128'(1));
    chk("rr_counter", 128'(mm_counter), 128'(0));
    chk("rr_lane_a", mm_inA_flat, '0);
    chk("rr_lane_b", mm_inB_flat, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rr_ld_ready", 128'(ld_ready), 128'(1));
    chk("rr_busy", 128'(busy), 128'(0));
    for (int r = 0; r < 4; r++) push(r[1:0], '0);
    do_start();
    wait_done("rr_done");
    drain(4'b1111);

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
